multu_seq_ctrl: RTL and testbench
=================================

# multu_seq_ctrl

Sequential controller for the ALU's 32×32 unsigned multiply (MIPS `multu`). It sequences a single 32-bit adder and a 65-bit product shift register over 32 iterations using a shift-and-add algorithm. It presents a start/busy/done handshake to the ALU top level and returns the 64-bit product as hi/lo words.

## Interface
Parameters:
- `WIDTH`, 32: operand width. The product is 2×`WIDTH` bits. Only 32 is verified.

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request a multiply. Sampled on the rising edge.
- `a`, input, 32: multiplicand. Sampled only on an accepted start.
- `b`, input, 32: multiplier. Sampled only on an accepted start.
- `busy`, output, 1: high while iterating.
- `done`, output, 1: one-cycle pulse; `hi`/`lo` hold the final product.
- `hi`, output, 32: upper product word.
- `lo`, output, 32: lower product word.

## Operation
State machine: IDLE, RUN, DONE.
- **IDLE**: `busy`=0, `done`=0. On `start`=1:
  - `mcand` ← `a`.
  - `prod` ← {1'b0, 32'h0, `b`}.
  - `cnt` ← 0.
  - Go to RUN.
- **RUN**: `busy`=1. Each cycle:
  - sum[32:0] = {1'b0, `prod`[63:32]} + (`prod`[0] ? {1'b0, `mcand`} : 0).
  - `prod` ← {sum, `prod`[31:1]}, i.e. the 65-bit {carry, hi, lo} shifted right by 1.
  - `cnt` ← `cnt` + 1.
  - When `cnt` == 31 on that edge, go to DONE.
- **DONE**: `busy`=0, `done`=1 for exactly this one cycle.
  - `start`=1 here is accepted with the same action as in IDLE and goes straight to RUN.
  - Otherwise go to IDLE.
- Width rules:
  - `cnt` is 5 bits and never wraps inside RUN.
  - The adder carry is kept in `prod`[64] for one iteration only.
  - The final product always fits in 64 bits, so bit 64 is 0 after the last iteration.
- `hi` = `prod`[63:32], `lo` = `prod`[31:0], driven directly from the register.
  - During RUN they show partial products and are not valid results.
  - After DONE they hold the product through IDLE until the next accepted start.
- `start` during RUN is ignored: no restart and no effect on operands.
- `a`/`b` may change freely after the accepting edge.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `cnt`=0, `mcand`=0.
- `rst` asserted at any point, including mid-RUN:
  - All outputs are forced to their reset values immediately, without waiting for a clock.
  - Any operation in flight is discarded.
  - After deassertion, the block accepts `start` on the first rising edge.
- Latency, with the start edge counted as edge 0:
  - `busy` rises after edge 0.
  - Exactly 32 RUN cycles follow.
  - At edge 32 the state becomes DONE, so `done` is high in the cycle following edge 32 (i.e. between edges 32 and 33).
- Throughput:
  - A start held high through the DONE cycle is accepted at edge 33.
  - Back-to-back multiplies therefore run every 33 cycles.
  - `done` and `busy` are never high at the same time.
- Combinational path: one 32-bit add per cycle, from the `prod`/`mcand` registers back to `prod`. There is no path from inputs to outputs.

## Test plan
- `a`=3, `b`=5, single start:
  - `busy` is high for 32 cycles.
  - `done` pulses one cycle later, with `hi`=0x00000000 and `lo`=0x0000000F.
  - The values hold through IDLE.
- `a`=0xFFFFFFFF, `b`=0xFFFFFFFF: at `done`, `hi`=0xFFFFFFFE and `lo`=0x00000001 (checks carry into bit 64 and its discard).
- `a`=0x12345678, `b`=0:
  - At `done`, `hi`=0 and `lo`=0.
  - Then `a`=0x80000000, `b`=2 with start held high through DONE: accepted at edge 33, next `done` shows `hi`=0x00000001, `lo`=0x00000000.
- Start `a`=7, `b`=9, then pulse `start` with `a`=100, `b`=100 at RUN cycle 10: the request is ignored, and `done` arrives on schedule with `lo`=63.
- Start `a`=0xDEADBEEF, `b`=0x10, assert `rst` asynchronously mid-cycle at RUN cycle 20:
  - All outputs go to 0 immediately.
  - After release, a new start with `a`=6, `b`=7 gives `lo`=42 after 33 cycles.
- Randomized check: 1000 random operand pairs against a 64-bit reference model, verifying the `done` timing and `hi`/`lo` values.

Source files
------------

// File: rtl/multu_seq_ctrl.sv
// multu_seq_ctrl: sequential shift-and-add controller for an unsigned
// WIDTH x WIDTH multiply. One WIDTH-bit add per cycle, WIDTH iterations,
// start/busy/done handshake, product returned as hi/lo words.
module multu_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_mcand;
  // {hi, lo}. The {carry, hi, lo} value is shifted right every iteration,
  // so the carry lands in the top bit of hi straight away and the bit
  // above it is always zero; it therefore needs no flop of its own.
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;

  // Final iteration is the one that sees the counter at WIDTH-1.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Single adder: add the multiplicand into the upper half when lsb is set.
  always_comb begin
    w_addend = r_prod[0] ? {1'b0, r_mcand} : '0;
    w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;
  end

  // State register; reset drops straight back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs. busy/done decode the state register
  // only, so an async reset clears them without waiting for a clock.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        // start is ignored here on purpose: no restart mid-operation.
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        // A request in the done cycle is taken immediately (33-cycle cadence).
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, shift-and-add while running,
  // otherwise hold so the product stays visible after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_mcand <= a;
      r_prod  <= {{WIDTH{1'b0}}, b};
      r_cnt   <= '0;
    end else if (w_step) begin
      r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign hi = r_prod[2*WIDTH-1:WIDTH];
  assign lo = r_prod[WIDTH-1:0];

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Testbench for multu_seq_ctrl: cycle-level behavioural model plus
// directed vectors with literal expected products.
module tb_multu_seq_ctrl;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  multu_seq_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Behavioural model: an operation is a 32-cycle countdown; when it
  // reaches zero the full product appears with a one-cycle done.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_res  = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) m_res = m_pend;
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_left = 32;
        m_pend = 64'(a) * 64'(b);
      end
    end
  end

  // Compare every cycle; hi/lo only carry meaning while not busy.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_left > 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      if (m_left == 0) begin
        chk("cyc_hi", 64'(hi), m_res[63:32]);
        chk("cyc_lo", 64'(lo), m_res[31:0]);
      end
    end
  end

  // Present a request for exactly one edge; returns 2 time units after it.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_);
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(posedge clk);
    #2;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Wait (bounded) for done; check how many negedges it took and the product.
  task automatic wait_done(input int exp_n, input logic [63:0] exp_p, input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({name, "_lat"}, 64'(n), 64'(exp_n));
    chk({name, "_hi"}, 64'(hi), 64'(exp_p[63:32]));
    chk({name, "_lo"}, 64'(lo), 64'(exp_p[31:0]));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    // 3 * 5, then hold through idle
    start_op(32'd3, 32'd5);
    wait_done(33, 64'h0000_0000_0000_000F, "m3x5");
    repeat (5) @(negedge clk);
    chk("hold_hi", 64'(hi), 64'h0);
    chk("hold_lo", 64'(lo), 64'hF);
    chk("hold_busy", 64'(busy), 64'd0);

    // All ones: exercises the carry out of the adder
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(33, 64'hFFFF_FFFE_0000_0001, "mffxff");

    // Zero multiplier, then back-to-back start taken in the done cycle
    start_op(32'h1234_5678, 32'd0);
    wait_done(33, 64'h0, "mzero");
    start = 1'b1;
    a     = 32'h8000_0000;
    b     = 32'd2;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(33, 64'h0000_0001_0000_0000, "b2b");

    // start during RUN must be ignored
    start_op(32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #2;
    start = 1'b1;
    a     = 32'd100;
    b     = 32'd100;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(22, 64'd63, "ignore");

    // Async reset mid-run
    start_op(32'hDEAD_BEEF, 32'h10);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi",   64'(hi),   64'd0);
    chk("arst_lo",   64'(lo),   64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    start_op(32'd6, 32'd7);
    wait_done(33, 64'd42, "post_rst");

    // Random operands
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 97 == 0) ra = 32'hFFFF_FFFF;
      if (i % 89 == 0) rb = 32'h8000_0001;
      start_op(ra, rb);
      wait_done(33, 64'(ra) * 64'(rb), "rand");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
